// File: rtl/vga_scanout_if.sv
// Bundles the scanout engine's framebuffer fetch port, palette write port and
// video outputs; master is the scanout engine, slave is the surrounding system.
interface vga_scanout_if #(
    parameter int FB_ADDR_BITS = 17,
    parameter int PIXEL_BITS   = 8,
    parameter int RED_BITS     = 4,
    parameter int GREEN_BITS   = 4,
    parameter int BLUE_BITS    = 4
);
    logic                                      enable;
    logic                                      fb_rd_en;
    logic [FB_ADDR_BITS-1:0]                   fb_addr;
    logic [PIXEL_BITS-1:0]                     fb_data;
    logic                                      pal_we;
    logic [PIXEL_BITS-1:0]                     pal_waddr;
    logic [RED_BITS+GREEN_BITS+BLUE_BITS-1:0]  pal_wdata;
    logic                                      vga_hs;
    logic                                      vga_vs;
    logic [RED_BITS-1:0]                       vga_r;
    logic [GREEN_BITS-1:0]                     vga_g;
    logic [BLUE_BITS-1:0]                      vga_b;
    logic                                      frame_start;
    logic                                      vblank_start;

    modport master (
        input  enable, fb_data, pal_we, pal_waddr, pal_wdata,
        output fb_rd_en, fb_addr, vga_hs, vga_vs, vga_r, vga_g, vga_b,
               frame_start, vblank_start
    );

    modport slave (
        output enable, fb_data, pal_we, pal_waddr, pal_wdata,
        input  fb_rd_en, fb_addr, vga_hs, vga_vs, vga_r, vga_g, vga_b,
               frame_start, vblank_start
    );
endinterface

// File: rtl/vga_scanout.sv
// VGA scanout: timing counters, incremental framebuffer addressing, palette
// lookup, and a control delay line that keeps syncs aligned with pixel colour.
module vga_scanout #(
    parameter int H_ACTIVE      = 800,
    parameter int H_FP          = 40,
    parameter int H_SYNC        = 128,
    parameter int H_BP          = 88,
    parameter int V_ACTIVE      = 600,
    parameter int V_FP          = 1,
    parameter int V_SYNC        = 4,
    parameter int V_BP          = 23,
    parameter bit HS_POL        = 1'b1,
    parameter bit VS_POL        = 1'b1,
    parameter int DOWNSCALE     = 2,
    parameter int PIXEL_BITS    = 8,
    parameter int RED_BITS      = 4,
    parameter int GREEN_BITS    = 4,
    parameter int BLUE_BITS     = 4,
    parameter int FETCH_LATENCY = 2
) (
    input  logic          vga_clk,
    input  logic          reset,
    vga_scanout_if.master bus
);
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_FB         = H_ACTIVE / DOWNSCALE;
    localparam int V_FB         = V_ACTIVE / DOWNSCALE;
    localparam int FB_ADDR_BITS = $clog2(H_FB * V_FB);
    localparam int L            = FETCH_LATENCY + 2;
    localparam int HW           = $clog2(H_TOTAL + 1);
    localparam int VW           = $clog2(V_TOTAL + 1);
    localparam int SW           = $clog2(DOWNSCALE + 1);
    localparam int RGB_BITS     = RED_BITS + GREEN_BITS + BLUE_BITS;

    typedef logic [FB_ADDR_BITS-1:0] addr_t;

    logic              run_p0, vld_p0, hs_p0, vs_p0, fs_p0, vb_p0;
    logic [HW-1:0]     h_p0;
    logic [VW-1:0]     v_p0;
    logic [SW-1:0]     hsub_p0, vsub_p0;
    addr_t             base_p0, addr_p0;

    logic              run_n, vld_n, hs_n, vs_n, fs_n, vb_n;
    logic [HW-1:0]     h_n;
    logic [VW-1:0]     v_n;
    logic [SW-1:0]     hsub_n, vsub_n;
    addr_t             base_n, addr_n;

    // Address advances by one every DOWNSCALE pixels; line base advances every DOWNSCALE lines.
    always_comb begin
        run_n  = 1'b0;
        h_n    = '0;
        v_n    = '0;
        hsub_n = '0;
        vsub_n = '0;
        base_n = '0;
        addr_n = '0;
        if (bus.enable && run_p0) begin
            run_n  = 1'b1;
            h_n    = h_p0 + HW'(1);
            v_n    = v_p0;
            hsub_n = hsub_p0;
            vsub_n = vsub_p0;
            base_n = base_p0;
            addr_n = addr_p0;
            if (h_p0 == HW'(H_TOTAL - 1)) begin
                h_n    = '0;
                hsub_n = '0;
                if (v_p0 == VW'(V_TOTAL - 1)) begin
                    v_n    = '0;
                    vsub_n = '0;
                    base_n = '0;
                end else begin
                    v_n = v_p0 + VW'(1);
                    if (vsub_p0 == SW'(DOWNSCALE - 1)) begin
                        vsub_n = '0;
                        if (v_n < VW'(V_ACTIVE))
                            base_n = base_p0 + addr_t'(H_FB);
                    end else begin
                        vsub_n = vsub_p0 + SW'(1);
                    end
                end
                addr_n = base_n;
            end else if (h_n < HW'(H_ACTIVE)) begin
                if (hsub_p0 == SW'(DOWNSCALE - 1)) begin
                    hsub_n = '0;
                    addr_n = addr_p0 + addr_t'(1);
                end else begin
                    hsub_n = hsub_p0 + SW'(1);
                end
            end
        end else if (bus.enable) begin
            run_n = 1'b1;
        end
    end

    always_comb begin
        vld_n = run_n && (h_n < HW'(H_ACTIVE)) && (v_n < VW'(V_ACTIVE));
        hs_n  = run_n && (h_n >= HW'(H_ACTIVE + H_FP)) && (h_n < HW'(H_ACTIVE + H_FP + H_SYNC));
        vs_n  = run_n && (v_n >= VW'(V_ACTIVE + V_FP)) && (v_n < VW'(V_ACTIVE + V_FP + V_SYNC));
        fs_n  = run_n && (h_n == '0) && (v_n == '0);
        vb_n  = run_n && (h_n == '0) && (v_n == VW'(V_ACTIVE));
    end

    // Stage 0: counters, address and undelayed control
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            run_p0  <= 1'b0;
            h_p0    <= '0;
            v_p0    <= '0;
            hsub_p0 <= '0;
            vsub_p0 <= '0;
            base_p0 <= '0;
            addr_p0 <= '0;
            vld_p0  <= 1'b0;
            hs_p0   <= 1'b0;
            vs_p0   <= 1'b0;
            fs_p0   <= 1'b0;
            vb_p0   <= 1'b0;
        end else begin
            run_p0  <= run_n;
            h_p0    <= h_n;
            v_p0    <= v_n;
            hsub_p0 <= hsub_n;
            vsub_p0 <= vsub_n;
            base_p0 <= base_n;
            addr_p0 <= addr_n;
            vld_p0  <= vld_n;
            hs_p0   <= hs_n;
            vs_p0   <= vs_n;
            fs_p0   <= fs_n;
            vb_p0   <= vb_n;
        end
    end

    assign bus.fb_rd_en     = vld_p0;
    assign bus.fb_addr      = addr_p0;
    assign bus.frame_start  = fs_p0;
    assign bus.vblank_start = vb_p0;

    logic [L-1:0] vld_dly, hs_dly, vs_dly;

    // Stages 1..L: control delay line matching fetch + palette + output register
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            vld_dly <= '0;
            hs_dly  <= '0;
            vs_dly  <= '0;
        end else begin
            vld_dly <= {vld_dly[L-2:0], vld_p0};
            hs_dly  <= {hs_dly[L-2:0], hs_p0};
            vs_dly  <= {vs_dly[L-2:0], vs_p0};
        end
    end

    logic [RGB_BITS-1:0] palette [2**PIXEL_BITS];
    logic [RGB_BITS-1:0] rgb_p1;
    logic [RGB_BITS-1:0] rgb_p2;

    // Palette read stage; non-blocking write makes a same-cycle read return the old entry.
    always_ff @(posedge vga_clk) begin
        if (bus.pal_we)
            palette[bus.pal_waddr] <= bus.pal_wdata;
        rgb_p1 <= palette[bus.fb_data];
    end

    // Output register stage
    always_ff @(posedge vga_clk) begin
        if (reset)
            rgb_p2 <= '0;
        else
            rgb_p2 <= vld_dly[L-2] ? rgb_p1 : '0;
    end

    assign bus.vga_hs = hs_dly[L-1] ^ ~HS_POL;
    assign bus.vga_vs = vs_dly[L-1] ^ ~VS_POL;
    assign bus.vga_r  = rgb_p2[RGB_BITS-1 -: RED_BITS];
    assign bus.vga_g  = rgb_p2[GREEN_BITS+BLUE_BITS-1 -: GREEN_BITS];
    assign bus.vga_b  = rgb_p2[BLUE_BITS-1:0];
endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a 14x8 total raster (8x4 active, downscale 2,
// fetch latency 2); a second instance with HS_POL=0 checks sync polarity.
module tb_vga_scanout;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    vga_scanout_if #(.FB_ADDR_BITS(3), .PIXEL_BITS(8), .RED_BITS(4), .GREEN_BITS(4), .BLUE_BITS(4)) bus1 ();
    vga_scanout_if #(.FB_ADDR_BITS(3), .PIXEL_BITS(8), .RED_BITS(4), .GREEN_BITS(4), .BLUE_BITS(4)) bus2 ();

    vga_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .DOWNSCALE(2), .PIXEL_BITS(8),
        .RED_BITS(4), .GREEN_BITS(4), .BLUE_BITS(4), .FETCH_LATENCY(2)
    ) dut (.vga_clk(clk), .reset(reset), .bus(bus1));

    vga_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .DOWNSCALE(2), .PIXEL_BITS(8),
        .RED_BITS(4), .GREEN_BITS(4), .BLUE_BITS(4), .FETCH_LATENCY(2)
    ) dut_neg (.vga_clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    assign bus2.enable    = bus1.enable;
    assign bus2.pal_we    = bus1.pal_we;
    assign bus2.pal_waddr = bus1.pal_waddr;
    assign bus2.pal_wdata = bus1.pal_wdata;
    assign bus2.fb_data   = bus1.fb_data;

    // Framebuffer with two-cycle latency whose contents equal the address.
    logic [2:0] mem_addr_d;
    always @(posedge clk) begin
        mem_addr_d    <= bus1.fb_addr;
        bus1.fb_data  <= {5'd0, mem_addr_d};
    end

    // Reference model history, indexed by cycle number.
    bit          m_act [0:511];
    bit          m_hs  [0:511];
    bit          m_vs  [0:511];
    bit          m_rst [0:511];
    int          m_addr[0:511];
    logic [11:0] rd_val[0:511];
    logic [11:0] pal_m [0:7];
    bit          run_m = 1'b0;
    int          mh = 0;
    int          mv = 0;
    int          cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        bit          e_hs, e_vs, e_fs, e_vb, blank;
        logic [11:0] e_rgb;
        @(posedge clk);
        cyc++;
        m_rst[cyc] = reset;
        if (reset || !bus1.enable) begin
            run_m = 1'b0; mh = 0; mv = 0;
        end else if (!run_m) begin
            run_m = 1'b1; mh = 0; mv = 0;
        end else if (mh == 13) begin
            mh = 0;
            mv = (mv == 7) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        m_act[cyc]  = run_m && mh < 8 && mv < 4;
        m_hs[cyc]   = run_m && mh >= 10 && mh < 13;
        m_vs[cyc]   = run_m && mv >= 5 && mv < 7;
        m_addr[cyc] = (mv / 2) * 4 + mh / 2;
        e_fs        = run_m && mh == 0 && mv == 0;
        e_vb        = run_m && mh == 0 && mv == 4;
        rd_val[cyc] = (cyc >= 3) ? pal_m[m_addr[cyc-3] & 7] : 12'h000;
        if (bus1.pal_we)
            pal_m[bus1.pal_waddr[2:0]] = bus1.pal_wdata;
        e_hs  = 1'b0;
        e_vs  = 1'b0;
        e_rgb = 12'h000;
        blank = 1'b1;
        if (cyc >= 4)
            blank = m_rst[cyc] || m_rst[cyc-1] || m_rst[cyc-2] || m_rst[cyc-3];
        if (!blank) begin
            e_hs  = m_hs[cyc-4];
            e_vs  = m_vs[cyc-4];
            e_rgb = m_act[cyc-4] ? rd_val[cyc-1] : 12'h000;
        end
        #1;
        check_val("fb_rd_en", 32'(bus1.fb_rd_en), 32'(m_act[cyc]));
        check_val("frame_start", 32'(bus1.frame_start), 32'(e_fs));
        check_val("vblank_start", 32'(bus1.vblank_start), 32'(e_vb));
        if (m_act[cyc])
            check_val("fb_addr", 32'(bus1.fb_addr), 32'(m_addr[cyc]));
        check_val("vga_hs", 32'(bus1.vga_hs), 32'(e_hs));
        check_val("vga_hs_pol0", 32'(bus2.vga_hs), 32'(!e_hs));
        check_val("vga_vs", 32'(bus1.vga_vs), 32'(e_vs));
        check_val("rgb", 32'({bus1.vga_r, bus1.vga_g, bus1.vga_b}), 32'(e_rgb));
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_hs"}, 32'(bus1.vga_hs), 32'(0));
        check_val({tag, "_hs_pol0"}, 32'(bus2.vga_hs), 32'(1));
        check_val({tag, "_vs"}, 32'(bus1.vga_vs), 32'(0));
        check_val({tag, "_rgb"}, 32'({bus1.vga_r, bus1.vga_g, bus1.vga_b}), 32'(0));
        check_val({tag, "_rd_en"}, 32'(bus1.fb_rd_en), 32'(0));
        check_val({tag, "_addr"}, 32'(bus1.fb_addr), 32'(0));
        check_val({tag, "_fs"}, 32'(bus1.frame_start), 32'(0));
        check_val({tag, "_vb"}, 32'(bus1.vblank_start), 32'(0));
    endtask

    initial begin
        int c0;
        int k;
        bus1.enable    = 1'b1;
        bus1.pal_we    = 1'b0;
        bus1.pal_waddr = 8'd0;
        bus1.pal_wdata = 12'h000;

        // Load palette[i] = 0x100*i while held in reset.
        for (int i = 0; i < 8; i++) begin
            bus1.pal_we    = 1'b1;
            bus1.pal_waddr = 8'(i);
            bus1.pal_wdata = 12'(12'h100 * i);
            step();
        end
        bus1.pal_we = 1'b0;
        step();
        step();
        step();
        check_reset_state("rst");

        reset = 1'b0;
        step();
        c0 = cyc;
        check_val("first_fs", 32'(bus1.frame_start), 32'(1));
        check_val("first_rd_en", 32'(bus1.fb_rd_en), 32'(1));

        for (k = 1; k <= 285; k++) begin
            step();
            if (k == 5)   check_val("px_h1_r", 32'(bus1.vga_r), 32'(0));
            if (k == 6)   check_val("px_h2_r", 32'(bus1.vga_r), 32'(1));
            if (k == 13)  check_val("hs_before", 32'(bus1.vga_hs), 32'(0));
            if (k == 14)  check_val("hs_first", 32'(bus1.vga_hs), 32'(1));
            if (k == 17)  check_val("hs_after", 32'(bus1.vga_hs), 32'(0));
            if (k == 56)  check_val("vblank_pulse", 32'(bus1.vblank_start), 32'(1));
            if (k == 150) check_val("white_px", 32'({bus1.vga_r, bus1.vga_g, bus1.vga_b}), 32'(12'hFFF));
            if (k == 234) check_val("collide_old", 32'({bus1.vga_r, bus1.vga_g, bus1.vga_b}), 32'(12'h123));
            if (k == 235) check_val("collide_new", 32'({bus1.vga_r, bus1.vga_g, bus1.vga_b}), 32'(12'hABC));
            if (k == 256) check_val("dis_rd_en", 32'(bus1.fb_rd_en), 32'(0));
            if (k == 260) begin
                check_val("dis_hs", 32'(bus1.vga_hs), 32'(0));
                check_val("dis_vs", 32'(bus1.vga_vs), 32'(0));
                check_val("dis_rgb", 32'({bus1.vga_r, bus1.vga_g, bus1.vga_b}), 32'(0));
            end
            if (k == 264) check_val("reen_fs", 32'(bus1.frame_start), 32'(1));
            if (k == 285) check_reset_state("midrst");

            bus1.pal_we = 1'b0;
            if (k >= 70 && k <= 77) begin
                bus1.pal_we    = 1'b1;
                bus1.pal_waddr = 8'(k - 70);
                bus1.pal_wdata = 12'hFFF;
            end
            if (k == 182) begin
                bus1.pal_we    = 1'b1;
                bus1.pal_waddr = 8'd3;
                bus1.pal_wdata = 12'h123;
            end
            if (k == 232) begin
                bus1.pal_we    = 1'b1;
                bus1.pal_waddr = 8'd3;
                bus1.pal_wdata = 12'hABC;
            end
            if (k == 255) bus1.enable = 1'b0;
            if (k == 263) bus1.enable = 1'b1;
            if (k == 284) reset = 1'b1;
        end
        if (cyc - c0 != 285)
            check_val("cycle_count", 32'(cyc - c0), 32'(285));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
